// File: rtl/shifter_arbiter.sv
// Two-port front end for a shared combinational shifter: arbitrates A/B, registers the operands
// onto the shifter inputs, captures the result and returns it through a per-port response handshake.
module shifter_arbiter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [AMT_W-1:0] a_amount,
  input  logic             a_left,
  output logic             a_resp_valid,
  input  logic             a_resp_ready,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic [AMT_W-1:0] b_amount,
  input  logic             b_left,
  output logic             b_resp_valid,
  input  logic             b_resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic [WIDTH-1:0] sh_string,
  output logic [AMT_W-1:0] sh_amount,
  output logic             sh_left,
  input  logic [WIDTH-1:0] sh_r
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_grant_b;
  logic             r_last_b;
  logic             r_a_resp_valid;
  logic             r_b_resp_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_resp_data;
  logic [WIDTH-1:0] r_sh_string;
  logic [AMT_W-1:0] r_sh_amount;
  logic             r_sh_left;

  logic w_idle;
  logic w_pick_b;
  logic w_accept;
  logic w_resp_ack;

  // B wins only when A is absent, or on a tie when round-robin says A went last.
  assign w_idle     = (r_state == S_IDLE);
  assign w_pick_b   = b_valid & (~a_valid | (RR_EN & ~r_last_b));
  assign w_accept   = w_idle & (a_valid | b_valid);
  assign w_resp_ack = r_grant_b ? b_resp_ready : a_resp_ready;

  assign a_ready      = w_idle & a_valid & ~w_pick_b;
  assign b_ready      = w_idle & w_pick_b;
  assign a_resp_valid = r_a_resp_valid;
  assign b_resp_valid = r_b_resp_valid;
  assign resp_data    = r_resp_data;
  assign busy         = r_busy;
  assign sh_string    = r_sh_string;
  assign sh_amount    = r_sh_amount;
  assign sh_left      = r_sh_left;

  // Operation sequencer: accept, drive shifter for one cycle, hold response until consumed.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_grant_b      <= 1'b0;
      r_last_b       <= 1'b1;
      r_a_resp_valid <= 1'b0;
      r_b_resp_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_resp_data    <= '0;
      r_sh_string    <= '0;
      r_sh_amount    <= '0;
      r_sh_left      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh_string <= w_pick_b ? b_data   : a_data;
            r_sh_amount <= w_pick_b ? b_amount : a_amount;
            r_sh_left   <= w_pick_b ? b_left   : a_left;
            r_grant_b   <= w_pick_b;
            r_last_b    <= w_pick_b;
            r_busy      <= 1'b1;
            r_state     <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_resp_data    <= sh_r;
          r_a_resp_valid <= ~r_grant_b;
          r_b_resp_valid <= r_grant_b;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_ack) begin
            r_a_resp_valid <= 1'b0;
            r_b_resp_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_a_resp_valid <= 1'b0;
          r_b_resp_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: directed scenarios with literal results plus random two-port traffic
// checked every cycle against a transaction-level reference model.
module tb_shifter_arbiter;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic a_valid = 0, a_ready, a_left = 0, a_resp_valid, a_resp_ready = 0;
  logic b_valid = 0, b_ready, b_left = 0, b_resp_valid, b_resp_ready = 0;
  logic [15:0] a_data = 0, b_data = 0, resp_data, sh_string, sh_r;
  logic [3:0]  a_amount = 0, b_amount = 0, sh_amount;
  logic busy, sh_left;

  logic a2_valid = 0, a2_ready, a2_resp_valid, a2_resp_ready = 0;
  logic b2_valid = 0, b2_ready, b2_resp_valid, b2_resp_ready = 0;
  logic [15:0] resp_data2, sh_string2, sh_r2;
  logic [3:0]  sh_amount2;
  logic busy2, sh_left2;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [15:0] hw_shift(logic [15:0] d, logic [3:0] n, logic l);
    return l ? (d << n) : 16'($signed(d) >>> n);
  endfunction

  assign sh_r  = hw_shift(sh_string, sh_amount, sh_left);
  assign sh_r2 = hw_shift(sh_string2, sh_amount2, sh_left2);

  shifter_arbiter #(.WIDTH(16), .AMT_W(4), .RR_EN(1'b1)) dut (
    .CLK(CLK), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amount(a_amount), .a_left(a_left),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amount(b_amount), .b_left(b_left),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .resp_data(resp_data), .busy(busy),
    .sh_string(sh_string), .sh_amount(sh_amount), .sh_left(sh_left), .sh_r(sh_r)
  );

  shifter_arbiter #(.WIDTH(16), .AMT_W(4), .RR_EN(1'b0)) dut_fp (
    .CLK(CLK), .reset(reset),
    .a_valid(a2_valid), .a_ready(a2_ready), .a_data(16'h94A5), .a_amount(4'd5), .a_left(1'b1),
    .a_resp_valid(a2_resp_valid), .a_resp_ready(a2_resp_ready),
    .b_valid(b2_valid), .b_ready(b2_ready), .b_data(16'h94A5), .b_amount(4'd15), .b_left(1'b0),
    .b_resp_valid(b2_resp_valid), .b_resp_ready(b2_resp_ready),
    .resp_data(resp_data2), .busy(busy2),
    .sh_string(sh_string2), .sh_amount(sh_amount2), .sh_left(sh_left2), .sh_r(sh_r2)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result built bit by bit from the shift rules.
  function automatic logic [15:0] ref_shift(logic [15:0] d, int n, bit l);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      if (l) r[i] = (i >= n) ? d[(i - n) & 15] : 1'b0;
      else   r[i] = (i + n < 16) ? d[(i + n) & 15] : d[15];
    end
    return r;
  endfunction

  function automatic bit pick_b(bit av, bit bv, bit last_b);
    return bv && (!av || !last_b);
  endfunction

  // Transaction model: one op in flight, aged in cycles since acceptance.
  bit m_busy, m_pb, m_last_b;
  int m_age;
  logic [15:0] m_res, m_sh_s;
  logic [3:0]  m_sh_a;
  logic        m_sh_l;

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_pb = 0; m_last_b = 1; m_age = 0;
      m_res = 0; m_sh_s = 0; m_sh_a = 0; m_sh_l = 0;
    end else if (m_busy) begin
      if (m_age >= 2 && (m_pb ? b_resp_ready : a_resp_ready)) m_busy = 0;
      else if (m_age < 2) m_age++;
    end else if (a_valid || b_valid) begin
      m_pb     = pick_b(a_valid, b_valid, m_last_b);
      m_last_b = m_pb;
      m_sh_s   = m_pb ? b_data : a_data;
      m_sh_a   = m_pb ? b_amount : a_amount;
      m_sh_l   = m_pb ? b_left : a_left;
      m_res    = ref_shift(m_sh_s, int'(m_sh_a), m_sh_l);
      m_busy   = 1;
      m_age    = 1;
    end
  end

  // Every-cycle comparison of the main DUT against the model.
  always @(negedge CLK) begin
    if (!reset) begin
      bit pb, in_resp;
      pb = pick_b(a_valid, b_valid, m_last_b);
      in_resp = m_busy && m_age >= 2;
      chk("a_ready", 32'(a_ready), 32'(!m_busy && a_valid && !pb));
      chk("b_ready", 32'(b_ready), 32'(!m_busy && pb));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("a_resp_valid", 32'(a_resp_valid), 32'(in_resp && !m_pb));
      chk("b_resp_valid", 32'(b_resp_valid), 32'(in_resp && m_pb));
      chk("sh_operands", {11'(0), sh_left, sh_amount, sh_string}, {11'(0), m_sh_l, m_sh_a, m_sh_s});
      if (in_resp) chk("resp_data", 32'(resp_data), 32'(m_res));
      chk("one_resp_valid", 32'(a_resp_valid && b_resp_valid), 0);
      chk("ready_while_busy", 32'((a_ready || b_ready) && busy), 0);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_ready(bit pb);
    int k = 0;
    @(negedge CLK);
    while (!(pb ? b_ready : a_ready) && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("accept_wait", 32'(k < 20), 1);
  endtask

  task automatic set_req(bit pb, logic [15:0] d, logic [3:0] n, logic l);
    if (pb) begin b_valid = 1; b_data = d; b_amount = n; b_left = l; end
    else    begin a_valid = 1; a_data = d; a_amount = n; a_left = l; end
  endtask

  task automatic do_op(bit pb, logic [15:0] d, logic [3:0] n, logic l, logic [15:0] exp);
    set_req(pb, d, n, l);
    wait_ready(pb);
    tick();
    a_valid = 0; b_valid = 0;
    @(negedge CLK);
    chk("resp_early", 32'(pb ? b_resp_valid : a_resp_valid), 0);
    @(negedge CLK);
    chk("resp_latency", 32'(pb ? b_resp_valid : a_resp_valid), 1);
    chk("other_resp", 32'(pb ? a_resp_valid : b_resp_valid), 0);
    chk("result", 32'(resp_data), 32'(exp));
    if (pb) b_resp_ready = 1; else a_resp_ready = 1;
    tick();
    a_resp_ready = 0; b_resp_ready = 0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_ready"}, 32'(a_ready | b_ready), 0);
    chk({tag, "_rv"}, 32'(a_resp_valid | b_resp_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_data"}, 32'(resp_data), 0);
    chk({tag, "_sh"}, {11'(0), sh_left, sh_amount, sh_string}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[$];
    int n2a, n2b, n_ops;
    bit acc_a, acc_b;

    #1 chk_reset_outputs("por");
    @(posedge CLK); #2 reset = 0;
    tick();

    // model pinning against hand-computed values
    chk("ref_pin_l", 32'(ref_shift(16'h94A5, 1, 1)), 32'h294A);
    chk("ref_pin_r", 32'(ref_shift(16'h94A5, 6, 0)), 32'hFE52);

    do_op(0, 16'h94A5, 4'd1, 1'b1, 16'h294A);
    do_op(1, 16'h94A5, 4'd6, 1'b0, 16'hFE52);
    do_op(1, 16'h14A5, 4'd6, 1'b0, 16'h0052);
    do_op(1, 16'h94A5, 4'd15, 1'b0, 16'hFFFF);

    // both ports held valid: RR alternates, fixed priority starves B
    set_req(0, 16'h94A5, 4'd5, 1'b1);
    set_req(1, 16'h94A5, 4'd15, 1'b0);
    a_resp_ready = 1; b_resp_ready = 1; a2_resp_ready = 1; b2_resp_ready = 1;
    a2_valid = 1; b2_valid = 1;
    n2a = 0; n2b = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (a_ready) gseq.push_back(0);
      if (b_ready) gseq.push_back(1);
      if (a2_ready) n2a++;
      if (b2_ready) n2b++;
      if (a_resp_valid) chk("rr_a_result", 32'(resp_data), 32'h94A0);
      if (b_resp_valid) chk("rr_b_result", 32'(resp_data), 32'hFFFF);
      if (a2_resp_valid) chk("fp_a_result", 32'(resp_data2), 32'h94A0);
      chk("fp_b_resp", 32'(b2_resp_valid), 0);
    end
    tick();
    a_valid = 0; b_valid = 0; a2_valid = 0; b2_valid = 0;
    chk("rr_grants", 32'(gseq.size()), 4);
    for (int i = 0; i < gseq.size(); i++) chk("rr_order", 32'(gseq[i]), 32'(i % 2));
    chk("fp_a_grants", 32'(n2a), 4);
    chk("fp_b_grants", 32'(n2b), 0);
    @(negedge CLK);
    chk("fp_idle", 32'(busy2), 0);
    tick();
    a_resp_ready = 0; b_resp_ready = 0; a2_resp_ready = 0; b2_resp_ready = 0;

    // backpressure with a waiting B request
    set_req(0, 16'h94A5, 4'd15, 1'b1);
    wait_ready(0);
    tick();
    a_valid = 0;
    set_req(1, 16'h1234, 4'd2, 1'b1);
    @(negedge CLK);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("bp_rv", 32'(a_resp_valid), 1);
      chk("bp_data", 32'(resp_data), 32'h8000);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_b_ready", 32'(b_ready), 0);
    end
    a_resp_ready = 1;
    tick();
    a_resp_ready = 0;
    @(negedge CLK);
    chk("bp_release_busy", 32'(busy), 0);
    chk("bp_release_rv", 32'(a_resp_valid), 0);
    tick();
    b_valid = 0; b_resp_ready = 1;
    repeat (4) tick();
    b_resp_ready = 0;

    // reset during SHIFT
    set_req(0, 16'h94A5, 4'd3, 1'b1);
    wait_ready(0);
    tick();
    a_valid = 0;
    #2 reset = 1;
    #1 chk_reset_outputs("rst_shift");
    @(posedge CLK); #2 reset = 0;
    repeat (4) begin
      @(negedge CLK);
      chk("rst_shift_no_resp", 32'(a_resp_valid | b_resp_valid), 0);
    end
    tick();

    // reset during RESP
    set_req(0, 16'h94A5, 4'd3, 1'b1);
    wait_ready(0);
    tick();
    a_valid = 0;
    tick();
    @(negedge CLK);
    chk("rst_resp_pre", 32'(a_resp_valid), 1);
    #2 reset = 1;
    #1 chk_reset_outputs("rst_resp");
    @(posedge CLK); #2 reset = 0;
    repeat (4) begin
      @(negedge CLK);
      chk("rst_resp_no_resp", 32'(a_resp_valid | b_resp_valid), 0);
    end
    tick();
    do_op(0, 16'h94A5, 4'd0, 1'b1, 16'h94A5);

    // random traffic
    n_ops = 0;
    for (int c = 0; c < 30000 && n_ops < 1000; c++) begin
      @(negedge CLK);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (acc_a) n_ops++;
      if (acc_b) n_ops++;
      if (acc_a || !a_valid) begin
        a_valid = 1'($urandom_range(0, 1));
        a_data = 16'($urandom); a_amount = 4'($urandom); a_left = 1'($urandom);
      end
      if (acc_b || !b_valid) begin
        b_valid = 1'($urandom_range(0, 1));
        b_data = 16'($urandom); b_amount = 4'($urandom); b_left = 1'($urandom);
      end
      a_resp_ready = ($urandom_range(0, 3) != 0);
      b_resp_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random_ops_done", 32'(n_ops >= 1000), 1);
    a_valid = 0; b_valid = 0; a_resp_ready = 1; b_resp_ready = 1;
    repeat (5) tick();
    @(negedge CLK);
    chk("drain_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
